// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: UART transmitter for ASCII characters, 8N1 (or 8N2), LSB first.
// It accepts one character at a time through a valid/ready handshake, and all
// of its outputs are registered.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic       tx,
    output logic       busy
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    logic bit_end;
    logic accept;

    assign bit_end     = (baud_q == BAUD_LAST);
    assign accept      = ascii_valid && ready_q;
    assign ascii_ready = ready_q;
    assign tx          = tx_q;
    assign busy        = busy_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && (bit_cnt_q == 3'd7)) state_d = STOP;
            STOP:  if (bit_end && (stop_cnt_q == STOP_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        baud_d     = baud_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;

        if (state_q == IDLE) begin
            baud_d = '0;
        end else if (bit_end) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d    = ascii_in;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) tx_d = shift_q[0];
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        // Shift after each data bit, so the next bit is always at shift_q[1].
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_d    = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

endmodule
